wrr_arbiter: RTL and testbench

Parametrised weighted round-robin arbiter. It is the N-requester successor to the 4-way rotating-priority arbiter. Grants are registered and held across multiple beats: each grant lasts until its per-requester weight quota is used up, the owner signals last, or the owner drops its request. It sits in front of shared buses and memory ports, where the owner needs a stable grant for a burst.

---
 rtl/wrr_arbiter.sv | 107 ++++++++++
 tb/tb_wrr_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: registered one-hot grant held for up to
// weight beats, released early on last or request drop.
module wrr_arbiter #(
  parameter int N  = 4,
  parameter int WW = 4,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*WW-1:0] weight,
  input  logic            ack,
  input  logic            last,
  output logic [N-1:0]    gnt,
  output logic [IW-1:0]   gnt_id,
  output logic            gnt_valid
);

  typedef enum logic {IDLE, OWNED} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IW-1:0]   gnt_id_q, gnt_id_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [WW-1:0]   credit_q, credit_d;

  logic [WW-1:0]   weight_arr [N];
  logic            rel;
  logic            found;
  logic [IW-1:0]   win;
  logic [WW-1:0]   win_weight;
  logic [WW-1:0]   eff_weight;

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      weight_arr[i] = weight[i*WW +: WW];
    end
  end

  always_comb begin
    rel = (state_q == OWNED) &&
          (!req[gnt_id_q] || (ack && last) || (ack && credit_q == WW'(1)));
  end

  // Circular scan starting at ptr; wrap is explicit so non-power-of-two N works.
  always_comb begin : search
    logic [IW-1:0] idx;
    found = 1'b0;
    win   = '0;
    idx   = ptr_q;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = (idx == IW'(N-1)) ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    win_weight = weight_arr[win];
    eff_weight = (win_weight == '0) ? WW'(1) : win_weight;
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    if (state_q == OWNED && !rel) begin
      if (ack) begin
        credit_d = credit_q - 1'b1;
      end
    end else if (found) begin
      state_d  = OWNED;
      gnt_d    = {{(N-1){1'b0}}, 1'b1} << win;
      gnt_id_d = win;
      credit_d = eff_weight;
      ptr_d    = (win == IW'(N-1)) ? '0 : win + 1'b1;
    end else begin
      state_d = IDLE;
      gnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = (state_q == OWNED);

endmodule

// File: tb/tb_wrr_arbiter.sv
// Scoreboard bench for wrr_arbiter: N=4 and N=5 instances checked every cycle
// against an owner/remaining-beats reference model.
module tb_wrr_arbiter;
  localparam int WW = 4;
  localparam int NA = 4;
  localparam int NB = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_a, ack_a, last_a, gnt_valid_a;
  logic [NA-1:0]    req_a, gnt_a;
  logic [NA*WW-1:0] weight_a;
  logic [1:0]       gnt_id_a;

  logic             rst_b, ack_b, last_b, gnt_valid_b;
  logic [NB-1:0]    req_b, gnt_b;
  logic [NB*WW-1:0] weight_b;
  logic [2:0]       gnt_id_b;

  wrr_arbiter #(.N(NA), .WW(WW)) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .weight(weight_a), .ack(ack_a),
    .last(last_a), .gnt(gnt_a), .gnt_id(gnt_id_a), .gnt_valid(gnt_valid_a)
  );

  wrr_arbiter #(.N(NB), .WW(WW)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .weight(weight_b), .ack(ack_b),
    .last(last_b), .gnt(gnt_b), .gnt_id(gnt_id_b), .gnt_valid(gnt_valid_b)
  );

  typedef struct {
    int owner;
    int rem;
    int ptr;
  } mstate_t;

  mstate_t ma, mb;
  int wa[32], wb[32];
  int qa[$], qb[$];
  int oa[$], ob[$];
  int exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference: owner index (-1 = none), beats remaining, next search start.
  function automatic void mstep(inout mstate_t s, input int n, input logic [31:0] r,
                                input int w[32], input bit rs, input bit a, input bit l);
    bit free;
    if (rs) begin
      s.owner = -1; s.rem = 0; s.ptr = 0;
      return;
    end
    free = (s.owner < 0);
    if (!free) begin
      if (!r[s.owner[4:0]])            free = 1'b1;
      else if (a && (l || s.rem == 1)) free = 1'b1;
      else if (a)                      s.rem--;
    end
    if (free) begin
      s.owner = -1;
      for (int k = 0; k < n; k++) begin
        int c = (s.ptr + k) % n;
        if (r[c[4:0]]) begin
          s.owner = c;
          s.rem   = (w[c[4:0]] == 0) ? 1 : w[c[4:0]];
          s.ptr   = (c + 1) % n;
          break;
        end
      end
    end
  endfunction

  function automatic int check(input string nm, input int e, input logic [31:0] g,
                               input logic v, input int id);
    logic [31:0] eg;
    bit ok;
    eg = (e >= 0) ? (32'd1 << e) : '0;
    ok = (v === (e >= 0)) && (g === eg) && (e < 0 || id == e);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s @%0t: gnt=%0h gnt_valid=%0b gnt_id=%0d, required gnt=%0h gnt_valid=%0b gnt_id=%0d",
                  nm, $time, g, v, id, eg, (e >= 0), e);
    return v ? id : -1;
  endfunction

  function automatic void seq_check(input string nm, input int got[$], input int want[$]);
    bit ok;
    ok = (got.size() == want.size());
    for (int i = 0; ok && i < want.size(); i++) if (got[i] != want[i]) ok = 1'b0;
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: observed gnt_id sequence %p, required %p", nm, got, want);
  endfunction

  always begin
    @(posedge clk);
    #1;
    if (qa.size() > 0)
      oa.push_back(check("dut_a_grant", qa.pop_front(), 32'(gnt_a), gnt_valid_a, int'(gnt_id_a)));
    if (qb.size() > 0)
      ob.push_back(check("dut_b_grant", qb.pop_front(), 32'(gnt_b), gnt_valid_b, int'(gnt_id_b)));
  end

  // Inputs set at a negedge apply to the next posedge; the model steps on the same values.
  task automatic tick();
    for (int i = 0; i < NA; i++) weight_a[i*WW +: WW] = 4'(wa[i]);
    for (int i = 0; i < NB; i++) weight_b[i*WW +: WW] = 4'(wb[i]);
    mstep(ma, NA, 32'(req_a), wa, rst_a, ack_a, last_a);
    qa.push_back(ma.owner);
    mstep(mb, NB, 32'(req_b), wb, rst_b, ack_b, last_b);
    qb.push_back(mb.owner);
    @(negedge clk);
  endtask

  task automatic da(input bit r, input logic [NA-1:0] q, input bit a, input bit l, input int cyc);
    rst_a = r; req_a = q; ack_a = a; last_a = l;
    repeat (cyc) tick();
  endtask

  task automatic db(input bit r, input logic [NB-1:0] q, input bit a, input bit l, input int cyc);
    rst_b = r; req_b = q; ack_b = a; last_b = l;
    repeat (cyc) tick();
  endtask

  initial begin
    rst_a = 1'b1; req_a = '0; ack_a = 1'b0; last_a = 1'b0;
    rst_b = 1'b1; req_b = '0; ack_b = 1'b0; last_b = 1'b0;
    ma = '{-1, 0, 0}; mb = '{-1, 0, 0};
    for (int i = 0; i < 32; i++) begin wa[i] = 1; wb[i] = 1; end
    @(negedge clk);

    // Reset with requests pending, then idle with stray acks.
    da(1'b1, 4'b1111, 1'b0, 1'b0, 2);
    da(1'b0, 4'b0000, 1'b1, 1'b0, 5);

    da(1'b1, 4'b1111, 1'b0, 1'b0, 1);
    oa.delete();
    da(1'b0, 4'b1111, 1'b1, 1'b0, 6);
    exp_q = '{0, 1, 2, 3, 0, 1};
    seq_check("fair_rotation", oa, exp_q);

    wa[0] = 3; wa[1] = 1; wa[2] = 2; wa[3] = 1;
    da(1'b1, 4'b1111, 1'b0, 1'b0, 1);
    oa.delete();
    da(1'b0, 4'b1111, 1'b1, 1'b0, 8);
    exp_q = '{0, 0, 0, 1, 2, 2, 3, 0};
    seq_check("weighted_rotation", oa, exp_q);
    oa.delete();
    da(1'b0, 4'b1111, 1'b0, 1'b0, 3);
    da(1'b0, 4'b1111, 1'b1, 1'b0, 4);
    exp_q = '{0, 0, 0, 0, 0, 1, 2};
    seq_check("ack_stall_stretch", oa, exp_q);

    for (int i = 0; i < NA; i++) wa[i] = 1;
    wa[1] = 8;
    da(1'b1, 4'b1111, 1'b0, 1'b0, 1);
    oa.delete();
    da(1'b0, 4'b0010, 1'b0, 1'b0, 1);
    da(1'b0, 4'b0110, 1'b1, 1'b0, 1);
    da(1'b0, 4'b0110, 1'b1, 1'b1, 1);
    da(1'b0, 4'b0110, 1'b0, 1'b0, 2);
    exp_q = '{1, 1, 2, 2, 2};
    seq_check("early_release_last", oa, exp_q);

    da(1'b1, 4'b1111, 1'b0, 1'b0, 1);
    oa.delete();
    da(1'b0, 4'b0010, 1'b0, 1'b0, 2);
    da(1'b0, 4'b1100, 1'b0, 1'b0, 1);
    exp_q = '{1, 1, 2};
    seq_check("release_on_drop", oa, exp_q);

    wa[2] = 3;
    da(1'b1, 4'b1111, 1'b0, 1'b0, 1);
    da(1'b0, 4'b0100, 1'b0, 1'b0, 1);
    da(1'b0, 4'b0100, 1'b1, 1'b0, 1);
    da(1'b1, 4'b1111, 1'b1, 1'b0, 1);
    oa.delete();
    da(1'b0, 4'b1111, 1'b0, 1'b0, 1);
    exp_q = '{0};
    seq_check("reset_mid_burst", oa, exp_q);

    for (int i = 0; i < NA; i++) wa[i] = 0;
    da(1'b1, 4'b1111, 1'b0, 1'b0, 1);
    oa.delete();
    da(1'b0, 4'b1111, 1'b1, 1'b0, 5);
    exp_q = '{0, 1, 2, 3, 0};
    seq_check("zero_weight", oa, exp_q);

    // Non-power-of-two instance; dut_a held in reset meanwhile.
    rst_a = 1'b1;
    db(1'b1, 5'b11111, 1'b0, 1'b0, 1);
    ob.delete();
    db(1'b0, 5'b10001, 1'b1, 1'b0, 6);
    exp_q = '{0, 4, 0, 4, 0, 4};
    seq_check("n5_wrap_alternation", ob, exp_q);
    ob.delete();
    db(1'b0, 5'b01000, 1'b1, 1'b0, 5);
    exp_q = '{3, 3, 3, 3, 3};
    seq_check("n5_lone_regrant", ob, exp_q);

    // Randomized traffic on both instances.
    rst_a = 1'b0; rst_b = 1'b0;
    for (int c = 0; c < 600; c++) begin
      rst_a  = ($urandom_range(0, 59) == 0);
      rst_b  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 2) == 0) req_a = 4'($urandom);
      if ($urandom_range(0, 2) == 0) req_b = 5'($urandom);
      ack_a  = ($urandom_range(0, 3) != 0);
      ack_b  = ($urandom_range(0, 3) != 0);
      last_a = ($urandom_range(0, 4) == 0);
      last_b = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < NB; i++) begin
        if ($urandom_range(0, 7) == 0) wa[i] = $urandom_range(0, 15);
        if ($urandom_range(0, 7) == 0) wb[i] = $urandom_range(0, 15);
      end
      tick();
    end

    for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++) @(negedge clk);
    n_checks++;
    if (qa.size() == 0 && qb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d/%0d entries left, required 0/0", qa.size(), qb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
